ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide engine in the EX stage; consumes the ID/EX pipeline register outputs for RV32M instructions (funct7 = 0000001).
- Holds IF, ID/EX and PC by asserting stall_o while an operation runs.
- Presents the result and its write-back tag to the EX/MEM register for one cycle.

Parameters:
- XLEN, 32, operand/result width.
- ZERO_SHORTCUT, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- valid_i  in  1  ID/EX holds a live (non-bubble) instruction.
- flush_i  in  1  abort current operation (branch/exception squash).
- RegWrite_i  in  1  ID/EX RegWrite.
- funct7_i  in  7  ID/EX funct7.
- funct3_i  in  3  ID/EX funct3.
- RS1data_i  in  XLEN  forwarded rs1 operand.
- RS2data_i  in  XLEN  forwarded rs2 operand.
- RDaddr_i  in  5  ID/EX destination register.
- stall_o  out  1  freeze PC, IF/ID, ID/EX.
- done_o  out  1  result valid this cycle (1-cycle pulse).
- result_o  out  XLEN  product low word / quotient / remainder.
- RDaddr_o  out  5  latched destination.
- RegWrite_o  out  1  latched RegWrite, qualified by done_o.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; stall_o=0, done_o=0, result_o=0, RDaddr_o=0, RegWrite_o=0; counter, accumulators, and sign flags cleared.
- start = valid_i & funct7_i==7'b0000001 & funct3_i in {000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU}. Other funct3 values are ignored (no stall).
- FSM states:
  - IDLE -> BUSY on start. Latch operands, op, RDaddr_i, RegWrite_i; cnt=XLEN-1.
  - IDLE -> DONE directly if ZERO_SHORTCUT=1 and the op is a divide with RS2=0 or signed overflow.
  - BUSY: one iteration per cycle.
    - MUL: shift-add on the unsigned operands. Only the low XLEN bits are kept; signedness is irrelevant.
    - DIV/REM: restoring divide on the magnitudes. The quotient is negated if the operand signs differ (DIV); the remainder takes the dividend sign (REM).
    - BUSY -> DONE when cnt==0. Total latency: start cycle + 32 BUSY cycles, then DONE.
  - DONE: done_o=1 for exactly one cycle; result_o, RDaddr_o, and RegWrite_o are valid. DONE -> IDLE unconditionally. start is ignored while in DONE, because ID/EX still holds the same instruction and it must not re-issue.
- stall_o = (IDLE & start) | BUSY. It is combinational so the start cycle freezes ID/EX. stall_o=0 in DONE, so the pipeline advances on that edge.
- Special results (RISC-V spec):
  - DIV/DIVU by 0: quotient = all ones.
  - REM/REMU by 0: remainder = dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - These values are identical whether ZERO_SHORTCUT is 0 or 1; only latency differs.
- flush_i:
  - In BUSY or DONE: return to IDLE next edge, done_o suppressed, stall_o deasserted combinationally that cycle.
  - In IDLE: suppresses start.
  - flush_i has priority over start.
- Outside DONE: RegWrite_o=0, and result_o/RDaddr_o hold their last values.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no done_o is emitted.

Decomposition:
- Shared package (riscv_pkg):
  - OPCODE/funct constants: FUNCT7_MULDIV, F3_MUL, F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One sub-module: muldiv_datapath. It holds the iterative shift/accumulate registers and the step logic, driven by load/step enables from the FSM in the top block.

Test Plan:
- MUL 7 x 6, RDaddr=5, RegWrite=1 -> stall_o high for 33 cycles, then done_o=1 with result_o=42, RDaddr_o=5, RegWrite_o=1.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0x00000001. DIV -20/3 -> 0xFFFFFFFA (-6); REM -20/3 -> 0xFFFFFFFE (-2).
- DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100. Both have done_o 1 cycle after start when ZERO_SHORTCUT=1, and after 33 cycles when ZERO_SHORTCUT=0.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000; REM of the same operands -> 0.
- Start DIVU, assert flush_i at BUSY cycle 10 -> stall_o=0 that cycle, IDLE next edge, no done_o; the next valid MUL 3x3 -> 9.
- Assert rst_i at BUSY cycle 5 -> all outputs 0 immediately. Also: hold an identical ID/EX MUL through DONE -> exactly one done_o pulse, no re-issue.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M decode constants and the multiply/divide FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // MULH/MULHSU/MULHU are not handled by this engine.
  function automatic logic is_handled_f3(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider sharing one set of registers.
module muldiv_datapath #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            op_mul_i,
  input  logic            op_signed_i,
  input  logic            op_rem_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] result_next_o
);

  // acc: product / partial remainder; x: multiplicand / quotient shifter; y: multiplier / divisor
  logic [XLEN-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic            is_mul_q, is_rem_q, neg_quot_q, neg_rem_q;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   tmp, diff;

  always_comb begin
    a_neg = op_signed_i & op_a_i[XLEN-1];
    b_neg = op_signed_i & op_b_i[XLEN-1];
    a_mag = a_neg ? -op_a_i : op_a_i;
    b_mag = b_neg ? -op_b_i : op_b_i;
    tmp   = {acc_q, x_q[XLEN-1]};
    diff  = tmp - {1'b0, y_q};
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    if (load_i) begin
      acc_d = '0;
      x_d   = op_mul_i ? op_a_i : a_mag;
      y_d   = op_mul_i ? op_b_i : b_mag;
    end else if (step_i) begin
      if (is_mul_q) begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end else if (tmp >= {1'b0, y_q}) begin
        acc_d = diff[XLEN-1:0];
        x_d   = {x_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = tmp[XLEN-1:0];
        x_d   = {x_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    if (is_mul_q)      result_next_o = acc_d;
    else if (is_rem_q) result_next_o = neg_rem_q ? -acc_d : acc_d;
    else               result_next_o = neg_quot_q ? -x_d : x_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      is_mul_q   <= 1'b0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      if (load_i) begin
        is_mul_q   <= op_mul_i;
        is_rem_q   <= op_rem_i;
        // Divide-by-zero quotient stays all ones regardless of dividend sign.
        neg_quot_q <= (a_neg ^ b_neg) & (op_b_i != '0);
        neg_rem_q  <= a_neg;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M multiply/divide engine: stalls the front end while iterating and
// presents a one-cycle result with its write-back tag.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter bit          ZERO_SHORTCUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic            RegWrite_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] RS1data_i,
  input  logic [XLEN-1:0] RS2data_i,
  input  logic [4:0]      RDaddr_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      RDaddr_o,
  output logic            RegWrite_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      pend_rd_q, rd_q;
  logic            pend_rw_q, rw_q;
  logic [XLEN-1:0] result_q, special, dp_result;
  logic            start, shortcut, div_zero, div_ovf, load, step, finish;

  always_comb begin
    start    = valid_i & (funct7_i == FUNCT7_MULDIV) & is_handled_f3(funct3_i) & ~flush_i;
    div_zero = (RS2data_i == '0);
    div_ovf  = ~funct3_i[0] & (RS1data_i == {1'b1, {(XLEN-1){1'b0}}}) & (RS2data_i == '1);
    shortcut = ZERO_SHORTCUT && funct3_i[2] && (div_zero || div_ovf);
    if (div_zero) special = funct3_i[1] ? RS1data_i : '1;
    else          special = funct3_i[1] ? '0 : RS1data_i;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = shortcut ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall_o    = ((state_q == IDLE) & start) | ((state_q == BUSY) & ~flush_i);
  assign done_o     = (state_q == DONE) & ~flush_i;
  assign RegWrite_o = done_o & rw_q;
  assign RDaddr_o   = rd_q;
  assign result_o   = result_q;

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (load),
    .step_i        (step),
    .op_mul_i      (~funct3_i[2]),
    .op_signed_i   (~funct3_i[0]),
    .op_rem_i      (funct3_i[1]),
    .op_a_i        (RS1data_i),
    .op_b_i        (RS2data_i),
    .result_next_o (dp_result)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_rd_q <= '0;
      pend_rw_q <= 1'b0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q     <= CntW'(XLEN - 1);
        pend_rd_q <= RDaddr_i;
        pend_rw_q <= RegWrite_i;
      end else if (step) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Output tag only changes on entry to DONE so it holds otherwise.
      if (load && shortcut) begin
        result_q <= special;
        rd_q     <= RDaddr_i;
        rw_q     <= RegWrite_i;
      end else if (finish) begin
        result_q <= dp_result;
        rd_q     <= pend_rd_q;
        rw_q     <= pend_rw_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed scoreboard bench for ex_muldiv_unit, run against both shortcut settings.
module tb_ex_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid, flush, rw_in;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_in;

  logic        stall1, done1, rw1, stall0, done0, rw0;
  logic [31:0] res1, res0;
  logic [4:0]  rd1, rd0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .ZERO_SHORTCUT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush), .RegWrite_i(rw_in),
    .funct7_i(f7), .funct3_i(f3), .RS1data_i(rs1), .RS2data_i(rs2), .RDaddr_i(rd_in),
    .stall_o(stall1), .done_o(done1), .result_o(res1), .RDaddr_o(rd1), .RegWrite_o(rw1)
  );

  ex_muldiv_unit #(.XLEN(32), .ZERO_SHORTCUT(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush), .RegWrite_i(rw_in),
    .funct7_i(f7), .funct3_i(f3), .RS1data_i(rs1), .RS2data_i(rs2), .RDaddr_i(rd_in),
    .stall_o(stall0), .done_o(done0), .result_o(res0), .RDaddr_o(rd0), .RegWrite_o(rw0)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic count_done(input int n, output int c1, output int c0);
    c1 = 0;
    c0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done1) c1++;
      if (done0) c0++;
    end
  endtask

  // Issue one op to both units; valid is held across the DONE edge to prove no re-issue.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic w,
                        input logic [31:0] res, input int lat1);
    exp_t        e;
    int          lat = 0, l1 = 0, l0 = 0, sc = 0;
    logic        d1 = 1'b0, d0 = 1'b0, w1, w0;
    logic [31:0] r1, r0;
    logic [4:0]  a1;
    sb.push_back('{res, rd, w, lat1});
    @(negedge clk);
    valid = 1'b1; f7 = FUNCT7_MULDIV; f3 = op; rs1 = a; rs2 = b; rd_in = rd; rw_in = w;
    #1;
    if (stall1) sc++;
    while (!(d1 && d0) && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!d1) begin
        if (done1) begin
          d1 = 1'b1; l1 = lat; r1 = res1; a1 = rd1; w1 = rw1;
        end else if (stall1) begin
          sc++;
        end
      end
      if (!d0 && done0) begin
        d0 = 1'b1; l0 = lat; r0 = res0; w0 = rw0;
      end
      if ((d1 || d0) && valid) begin
        @(posedge clk);
        #1 valid = 1'b0;
      end
    end
    valid = 1'b0;
    e = sb.pop_front();
    check({name, "_finished"}, {31'b0, d1 & d0}, 32'd1);
    check({name, "_res"}, r1, e.res);
    check({name, "_res_noshort"}, r0, e.res);
    check({name, "_rd"}, {27'b0, a1}, {27'b0, e.rd});
    check({name, "_rw"}, {31'b0, w1}, {31'b0, e.rw});
    check({name, "_rw_noshort"}, {31'b0, w0}, {31'b0, e.rw});
    check({name, "_lat"}, l1, e.lat);
    check({name, "_lat_noshort"}, l0, 32'd33);
    check({name, "_stall_cycles"}, sc, e.lat);
  endtask

  initial begin
    int c1, c0;
    valid = 1'b0; flush = 1'b0; rw_in = 1'b0; f7 = '0; f3 = '0;
    rs1 = '0; rs2 = '0; rd_in = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, stall1}, 32'd0);
    check("rst_done", {31'b0, done1}, 32'd0);
    check("rst_result", res1, 32'd0);
    check("rst_rd", {27'b0, rd1}, 32'd0);
    check("rst_rw", {31'b0, rw1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul7x6", F3_MUL, 32'd7, 32'd6, 5'd5, 1'b1, 32'd42, 33);
    @(negedge clk);
    check("after_done_stall", {31'b0, stall1}, 32'd0);
    count_done(40, c1, c0);
    check("no_reissue", c1, 32'd0);

    run_op("mul_ones", F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'h1, 33);
    run_op("mul_norw", F3_MUL, 32'h0001_0003, 32'h0000_0100, 5'd7, 1'b0, 32'h0100_0300, 33);
    run_op("div_m20_3", F3_DIV, -32'sd20, 32'd3, 5'd8, 1'b1, 32'hFFFF_FFFA, 33);
    run_op("rem_m20_3", F3_REM, -32'sd20, 32'd3, 5'd8, 1'b1, 32'hFFFF_FFFE, 33);
    run_op("div_20_m3", F3_DIV, 32'd20, -32'sd3, 5'd9, 1'b1, 32'hFFFF_FFFA, 33);
    run_op("rem_20_m3", F3_REM, 32'd20, -32'sd3, 5'd9, 1'b1, 32'd2, 33);
    run_op("divu_big", F3_DIVU, 32'hFFFF_FFFE, 32'd2, 5'd10, 1'b1, 32'h7FFF_FFFF, 33);
    run_op("divu_by0", F3_DIVU, 32'd100, 32'd0, 5'd11, 1'b1, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", F3_REMU, 32'd100, 32'd0, 5'd12, 1'b1, 32'd100, 1);
    run_op("div_neg_by0", F3_DIV, -32'sd7, 32'd0, 5'd13, 1'b1, 32'hFFFF_FFFF, 1);
    run_op("rem_neg_by0", F3_REM, -32'sd7, 32'd0, 5'd13, 1'b1, 32'hFFFF_FFF9, 1);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'h8000_0000, 1);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'd0, 1);

    // MULH and non-M funct7 must not start the engine.
    @(negedge clk);
    valid = 1'b1; f7 = FUNCT7_MULDIV; f3 = 3'b001; rs1 = 32'd3; rs2 = 32'd4;
    #1 check("mulh_ignored_stall", {31'b0, stall1}, 32'd0);
    @(negedge clk);
    f7 = 7'b0000000; f3 = F3_MUL;
    #1 check("add_ignored_stall", {31'b0, stall1}, 32'd0);
    count_done(5, c1, c0);
    check("ignored_no_done", c1 + c0, 32'd0);
    valid = 1'b0;

    // Flush at the tenth BUSY cycle.
    @(negedge clk);
    valid = 1'b1; f7 = FUNCT7_MULDIV; f3 = F3_DIVU; rs1 = 32'd1000; rs2 = 32'd7;
    rd_in = 5'd15; rw_in = 1'b1;
    repeat (10) @(negedge clk);
    check("flush_busy_before", {31'b0, stall1}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, stall1}, 32'd0);
    check("flush_stall_noshort", {31'b0, stall0}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", {31'b0, stall1}, 32'd0);
    count_done(40, c1, c0);
    check("flush_no_done", c1 + c0, 32'd0);
    run_op("mul3x3", F3_MUL, 32'd3, 32'd3, 5'd16, 1'b1, 32'd9, 33);

    // Asynchronous reset at the fifth BUSY cycle.
    @(negedge clk);
    valid = 1'b1; f7 = FUNCT7_MULDIV; f3 = F3_MUL; rs1 = 32'd5; rs2 = 32'd5;
    rd_in = 5'd17; rw_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_busy_before", {31'b0, stall1}, 32'd1);
    rst = 1'b1; valid = 1'b0;
    #1;
    check("rst_mid_stall", {31'b0, stall1}, 32'd0);
    check("rst_mid_done", {31'b0, done1}, 32'd0);
    check("rst_mid_result", res1, 32'd0);
    check("rst_mid_rd", {27'b0, rd1}, 32'd0);
    check("rst_mid_rw", {31'b0, rw1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, c1, c0);
    check("rst_no_done", c1 + c0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
